// File: rtl/reg_wb_arbiter.sv
// Two-requester round-robin write-back arbiter feeding one register-file port.
// Address 0 is the hard-wired zero register: accepted, never written.
module reg_wb_arbiter #(
  parameter int BIT = 8,
  parameter int SZB = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           freeze,
  input  logic           req0_valid,
  input  logic [SZB-1:0] req0_addr,
  input  logic [BIT-1:0] req0_data,
  input  logic           req1_valid,
  input  logic [SZB-1:0] req1_addr,
  input  logic [BIT-1:0] req1_data,
  output logic           req0_ready,
  output logic           req1_ready,
  output logic           we,
  output logic [SZB-1:0] addr_rd,
  output logic [BIT-1:0] rd,
  output logic [7:0]     wr_count
);

  logic           r_prio;
  logic           r_we;
  logic [SZB-1:0] r_addr;
  logic [BIT-1:0] r_data;
  logic [7:0]     r_cnt;

  logic           w_gnt0;
  logic           w_gnt1;
  logic           w_xfer;
  logic [SZB-1:0] w_addr;
  logic [BIT-1:0] w_data;
  logic           w_we_nxt;

  // Grant is gated by reset so nothing transfers while it is held.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset && !freeze) begin
      w_gnt0 = req0_valid && (!req1_valid || !r_prio);
      w_gnt1 = req1_valid && (!req0_valid ||  r_prio);
    end
    w_xfer   = w_gnt0 || w_gnt1;
    w_addr   = w_gnt1 ? req1_addr : req0_addr;
    w_data   = w_gnt1 ? req1_data : req0_data;
    w_we_nxt = w_xfer && (w_addr != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= 8'd0;
    end else begin
      r_we <= w_we_nxt;
      if (w_xfer) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_prio <= w_gnt0;
      end
      if (w_we_nxt && (r_cnt != 8'hFF))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign we         = r_we;
  assign addr_rd    = r_addr;
  assign rd         = r_data;
  assign wr_count   = r_cnt;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed steps plus random traffic
// checked against a transaction-level round-robin model.
module tb_reg_wb_arbiter;

  localparam int BIT = 8;
  localparam int SZB = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           freeze;
  logic           req0_valid, req1_valid;
  logic [SZB-1:0] req0_addr, req1_addr;
  logic [BIT-1:0] req0_data, req1_data;
  logic           req0_ready, req1_ready;
  logic           we;
  logic [SZB-1:0] addr_rd;
  logic [BIT-1:0] rd;
  logic [7:0]     wr_count;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  int           m_prio;
  bit           m_we;
  int           m_addr;
  int           m_data;
  int           m_cnt;
  int           m_who;

  always #5 clock = ~clock;

  reg_wb_arbiter #(.BIT(BIT), .SZB(SZB)) dut (
    .clock      (clock),
    .reset      (reset),
    .freeze     (freeze),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .we         (we),
    .addr_rd    (addr_rd),
    .rd         (rd),
    .wr_count   (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0;
    m_we   = 0;
    m_addr = 0;
    m_data = 0;
    m_cnt  = 0;
  endtask

  // -1: no grant, 0: req0, 1: req1
  function automatic int winner();
    if (reset || freeze) return -1;
    if (req0_valid && req1_valid) return m_prio;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".we"},   32'(we),       32'(m_we));
    chk({tag, ".addr"}, 32'(addr_rd),  32'(m_addr));
    chk({tag, ".rd"},   32'(rd),       32'(m_data));
    chk({tag, ".cnt"},  32'(wr_count), 32'(m_cnt));
  endtask

  // Entered just after a negedge; leaves just after the next negedge.
  task automatic cycle(input string tag,
                       input bit v0, input int a0, input int d0,
                       input bit v1, input int a1, input int d1,
                       input bit frz);
    int ga, gd;
    req0_valid = v0; req0_addr = SZB'(a0); req0_data = BIT'(d0);
    req1_valid = v1; req1_addr = SZB'(a1); req1_data = BIT'(d1);
    freeze     = frz;
    #1;
    m_who = winner();
    chk({tag, ".rdy0"}, 32'(req0_ready), 32'(m_who == 0));
    chk({tag, ".rdy1"}, 32'(req1_ready), 32'(m_who == 1));
    @(posedge clock);
    if (m_who < 0) begin
      m_we = 0;
    end else begin
      ga     = (m_who == 0) ? (a0 % 16) : (a1 % 16);
      gd     = (m_who == 0) ? (d0 % 256) : (d1 % 256);
      m_addr = ga;
      m_data = gd;
      m_we   = (ga != 0);
      m_prio = (m_who == 0) ? 1 : 0;
      if (m_we && m_cnt < 255) m_cnt++;
    end
    @(negedge clock);
    chk_outs(tag);
  endtask

  initial begin
    int pre_prio;
    reset = 1'b1; freeze = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst.rdy0", 32'(req0_ready), 32'd0);
    chk("rst.rdy1", 32'(req1_ready), 32'd0);
    chk_outs("rst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // single requester
    cycle("single", 1, 3, 'h5A, 0, 7, 'h99, 0);
    chk("single.cnt1", 32'(wr_count), 32'd1);
    cycle("idle", 0, 0, 0, 0, 0, 0, 0);

    // back to back alternation from a fresh reset
    reset = 1'b1; #1; model_reset(); @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle("rr", 1, 1, 'h11, 1, 2, 'h22, 0);
      chk("rr.addr_seq", 32'(addr_rd), 32'((i % 2) + 1));
    end

    // address zero dropped, prio still advances
    cycle("zero", 0, 0, 0, 1, 0, 'hFF, 0);
    chk("zero.we", 32'(we), 32'd0);
    cycle("zero.after", 1, 4, 'h44, 1, 5, 'h55, 0);
    chk("zero.winner", 32'(addr_rd), 32'd4);

    // freeze for three cycles
    pre_prio = m_prio;
    for (int i = 0; i < 3; i++)
      cycle("frz", 1, 6, 'h66, 1, 9, 'h99, 1);
    cycle("frz.rel", 1, 6, 'h66, 1, 9, 'h99, 0);
    chk("frz.rel.who", 32'(addr_rd), 32'((pre_prio == 0) ? 6 : 9));

    // saturation
    for (int i = 0; i < 300; i++)
      cycle("sat", 1, 1 + (i % 15), i, 0, 0, 0, 0);
    chk("sat.255", 32'(wr_count), 32'd255);

    // reset mid-operation
    reset = 1'b1; #1; model_reset(); @(negedge clock); reset = 1'b0;
    cycle("mid.xfer", 1, 5, 'h77, 0, 0, 0, 0);
    req0_valid = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    chk_outs("mid.rst");
    chk("mid.rdy0", 32'(req0_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    cycle("mid.post", 0, 0, 0, 0, 0, 0, 0);
    chk("mid.post.we", 32'(we), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle("rnd", 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255),
            1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255),
            ($urandom_range(0, 7) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter BIT, default 8, meaning register data width.
REQ-002 SHALL have parameter SZB, default 4, meaning register address width (2**SZB registers).
REQ-003 SHALL have port clock  input  1  single clock; all state on posedge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port freeze  input  1  pipeline stall; suppresses all grants while high.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1  requester has a write pending.
REQ-007 SHALL have ports req0_addr / req1_addr  input  SZB  destination register.
REQ-008 SHALL have ports req0_data / req1_data  input  BIT  write data.
REQ-009 SHALL have ports req0_ready / req1_ready  output  1  combinational grant; transfer when valid&ready.
REQ-010 SHALL have port we  output  1  registered write enable to the register file.
REQ-011 SHALL have port addr_rd  output  SZB  registered write address.
REQ-012 SHALL have port rd  output  BIT  registered write data.
REQ-013 SHALL have port wr_count  output  8  saturating count of committed writes.

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_ready high only when reqN_valid high and freeze low.
REQ-015 SHALL grant the sole valid requester when only one is valid, regardless of priority.
REQ-016 SHALL, when both are valid, grant the requester indicated by a 1-bit priority pointer prio (0 -> req0, 1 -> req1).
REQ-017 SHALL, after each transfer, set prio to the non-granted requester (round-robin); prio unchanged in cycles without a transfer.
REQ-018 SHALL register a transfer one cycle later: next-cycle addr_rd/rd = granted addr/data, we = 1 if granted addr != 0, else we = 0.
REQ-019 SHALL treat writes to address 0 as accepted (ready asserted, prio advances) but dropped (we = 0, wr_count unchanged).
REQ-020 SHALL drive we = 0 in any cycle following a cycle with no transfer; addr_rd and rd hold their last values.
REQ-021 SHALL give fixed latency of exactly 1 cycle from transfer to we; sustained throughput 1 write/cycle.
REQ-022 SHALL increment wr_count by 1 on each cycle where we is registered high, saturating at 255 (no wrap).
REQ-023 SHALL, while freeze is high, deassert both readies, hold prio and wr_count, and drive we = 0 from the following cycle.
REQ-024 SHALL treat valid as level-sensitive; requester may change addr/data while not granted with no effect.
REQ-025 SHALL guarantee no requester with valid held high waits more than 1 grant to the other (freeze excluded).

Reset
REQ-026 SHALL, on reset assertion, immediately clear we, addr_rd, rd, wr_count to 0 and prio to 0, independent of clock.
REQ-027 SHALL discard any write registered but not yet presented when reset asserts mid-operation.
REQ-028 SHALL hold both readies low while reset is high; first grant possible on the first posedge after deassertion.

Verification
REQ-029 SHALL pass: req0 only, addr=3 data=0x5A -> req0_ready=1 same cycle; next cycle we=1 addr_rd=3 rd=0x5A, wr_count=1.
REQ-030 SHALL pass: both valid continuously, req0 addr=1 data=0x11, req1 addr=2 data=0x22, from reset -> grants req0,req1,req0,req1; we=1 every cycle; addr_rd 1,2,1,2.
REQ-031 SHALL pass: req1 valid addr=0 data=0xFF -> req1_ready=1, next cycle we=0, wr_count unchanged, prio=0.
REQ-032 SHALL pass: both valid, freeze=1 for 3 cycles -> both readies 0, we=0 after first frozen cycle, prio held; on release granted requester = prio before freeze.
REQ-033 SHALL pass: 300 back-to-back nonzero-address writes -> wr_count stops at 255.
REQ-034 SHALL pass: reset asserted between clock edges the cycle after a transfer -> we, addr_rd, rd, wr_count drop to 0 immediately, no write issued after release.
